contador_faixa: RTL

Parametrised range counter for the game-timing datapath, successor to the half-range counter. Counts between a base value `BASE` and a top value `M-1`, in either direction, and either wraps or saturates at the range limits. Supports a synchronous range-checked load, boundary flags, a registered wrap pulse and a sticky load-error flag. It sits wherever game components need a bounded tick or score counter with a programmable restart point.

---
 rtl/contador_pkg.sv | 28 ++
 rtl/contador_faixa_cmp.sv | 23 ++
 rtl/contador_faixa.sv | 115 +++++++++++
 3 files changed

// File: rtl/contador_pkg.sv
// Shared constants and operation decode for the contador_* counter family.
package contador_pkg;

  localparam logic MODO_VOLTA  = 1'b0;
  localparam logic MODO_SATURA = 1'b1;
  localparam logic SOBE        = 1'b0;
  localparam logic DESCE       = 1'b1;

  typedef enum logic [1:0] {
    OP_NADA  = 2'd0,
    OP_ZERA  = 2'd1,
    OP_CARGA = 2'd2,
    OP_CONTA = 2'd3
  } op_e;

  // Only the highest-priority request acts on a given edge.
  function automatic op_e decodifica_op(input logic zera_s,
                                        input logic carrega,
                                        input logic conta);
    op_e op;
    op = OP_NADA;
    if (zera_s)       op = OP_ZERA;
    else if (carrega) op = OP_CARGA;
    else if (conta)   op = OP_CONTA;
    return op;
  endfunction

endpackage

// File: rtl/contador_faixa_cmp.sv
// Range comparators for contador_faixa: boundary flags from Q and load range check.
module faixa_cmp
  import contador_pkg::*;
#(
  parameter int M    = 100,
  parameter int N    = 7,
  parameter int BASE = M/2-1
) (
  input  logic [N-1:0] i_q,
  input  logic [N-1:0] i_dado,
  output logic         o_fim,
  output logic         o_meio,
  output logic         o_dado_ok
);

  localparam logic [N-1:0] TOP_N  = N'(M-1);
  localparam logic [N-1:0] BASE_N = N'(BASE);

  assign o_fim     = (i_q == TOP_N);
  assign o_meio    = (i_q == BASE_N);
  assign o_dado_ok = (i_dado >= BASE_N) && (i_dado <= TOP_N);

endmodule

// File: rtl/contador_faixa.sv
// Range counter BASE..M-1, up/down, wrap or saturate, with range-checked load.
// Down counting is only built when CONTADOR_FAIXA_DESCE_EN is defined.
module contador_faixa
  import contador_pkg::*;
#(
  parameter int M    = 100,
  parameter int N    = 7,
  parameter int BASE = M/2-1
) (
  input  logic         clock,
  input  logic         zera_as,
  input  logic         zera_s,
  input  logic         carrega,
  input  logic [N-1:0] dado,
  input  logic         conta,
  input  logic         desce,
  input  logic         modo,
  output logic [N-1:0] Q,
  output logic         fim,
  output logic         meio,
  output logic         volta,
  output logic         erro_carga
);

  localparam logic [N-1:0] TOP_N  = N'(M-1);
  localparam logic [N-1:0] BASE_N = N'(BASE);

  logic [N-1:0] r_q;
  logic         r_volta;
  logic         r_erro;

  logic [N-1:0] w_q_nxt;
  logic         w_volta_nxt;
  logic         w_erro_nxt;
  logic         w_fim;
  logic         w_meio;
  logic         w_dado_ok;
  op_e          w_op;

  faixa_cmp #(
    .M    (M),
    .N    (N),
    .BASE (BASE)
  ) u_cmp (
    .i_q       (r_q),
    .i_dado    (dado),
    .o_fim     (w_fim),
    .o_meio    (w_meio),
    .o_dado_ok (w_dado_ok)
  );

  assign w_op = decodifica_op(zera_s, carrega, conta);

`ifndef CONTADOR_FAIXA_DESCE_EN
  logic w_unused_desce;
  assign w_unused_desce = desce;
`endif

  always_comb begin
    w_q_nxt     = r_q;
    w_volta_nxt = 1'b0;
    w_erro_nxt  = r_erro;
    case (w_op)
      OP_ZERA: begin
        w_q_nxt    = BASE_N;
        w_erro_nxt = 1'b0;
      end
      OP_CARGA: begin
        // A rejected load leaves Q alone and latches the error.
        if (w_dado_ok) w_q_nxt    = dado;
        else           w_erro_nxt = 1'b1;
      end
      OP_CONTA: begin
`ifdef CONTADOR_FAIXA_DESCE_EN
        if (desce == DESCE) begin
          if (r_q > BASE_N) begin
            w_q_nxt = r_q - 1'b1;
          end else if (modo == MODO_VOLTA) begin
            w_q_nxt     = TOP_N;
            w_volta_nxt = 1'b1;
          end
        end else
`endif
        begin
          if (r_q < TOP_N) begin
            w_q_nxt = r_q + 1'b1;
          end else if (modo == MODO_VOLTA) begin
            w_q_nxt     = BASE_N;
            w_volta_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      r_q     <= BASE_N;
      r_volta <= 1'b0;
      r_erro  <= 1'b0;
    end else begin
      r_q     <= w_q_nxt;
      r_volta <= w_volta_nxt;
      r_erro  <= w_erro_nxt;
    end
  end

  assign Q          = r_q;
  assign fim        = w_fim;
  assign meio       = w_meio;
  assign volta      = r_volta;
  assign erro_carga = r_erro;

endmodule
